// File: rtl/axi_pr_request_fetcher.sv
// axi_pr_request_fetcher: AXI4-Lite read-only initiator that drains the PR
// request queue. Each fetched entry goes out as {ou_id, grid_slot} on a
// valid/ready stream. Completed fetches are counted in fetch_count.
// Optional build macro PR_FETCH_PEEK_BEFORE_POP_EN: the entry is first
// peeked and presented downstream. It is popped (and the two reads are
// compared) only after downstream acceptance.
module axi_pr_request_fetcher #(
  parameter int unsigned OU_ID_W     = 4,
  parameter int unsigned GRID_SLOT_W = 3,
  parameter logic [1:0]  PEEK_R_ADDR = 2'b01,
  parameter logic [1:0]  POP_R_ADDR  = 2'b10,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pr_request_pending,
  output logic [1:0]             m_axi_araddr,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [31:0]            m_axi_rdata,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [OU_ID_W-1:0]     req_ou_id,
  output logic [GRID_SLOT_W-1:0] req_grid_slot,
  output logic                   busy,
  output logic [CNT_W-1:0]       fetch_count,
  output logic                   mismatch
);

  localparam int unsigned FIELD_W = GRID_SLOT_W + OU_ID_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR     = 3'd1,
    S_R      = 3'd2,
    S_OUT    = 3'd3,
    S_POP_AR = 3'd4,
    S_POP_R  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             araddr_q, araddr_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic                   req_valid_q, req_valid_d;
  logic [OU_ID_W-1:0]     ou_id_q, ou_id_d;
  logic [GRID_SLOT_W-1:0] grid_slot_q, grid_slot_d;
  logic [CNT_W-1:0]       fetch_count_q, fetch_count_d;
  logic                   busy_q, busy_d;
  logic                   mismatch_q, mismatch_d;

`ifdef PR_FETCH_PEEK_BEFORE_POP_EN
  localparam logic [1:0] FIRST_R_ADDR = PEEK_R_ADDR;
  // Bits above the request fields carry no information.
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata[31:FIELD_W];
`else
  localparam logic [1:0] FIRST_R_ADDR = POP_R_ADDR;
  // Upper rdata bits and the peek address are not used in the pop-only build.
  logic unused_cfg;
  assign unused_cfg = ^{m_axi_rdata[31:FIELD_W], PEEK_R_ADDR};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one outstanding request, no new AR until delivered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pr_request_pending) state_d = S_AR;
      S_AR:   if (m_axi_arready)      state_d = S_R;
      S_R:    if (m_axi_rvalid)       state_d = S_OUT;
`ifdef PR_FETCH_PEEK_BEFORE_POP_EN
      S_OUT:    if (req_ready)     state_d = S_POP_AR;
      S_POP_AR: if (m_axi_arready) state_d = S_POP_R;
      S_POP_R:  if (m_axi_rvalid)  state_d = S_IDLE;
`else
      S_OUT:  if (req_ready)          state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered AXI/stream/status outputs.
  always_comb begin
    araddr_d      = araddr_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    req_valid_d   = req_valid_q;
    ou_id_d       = ou_id_q;
    grid_slot_d   = grid_slot_q;
    fetch_count_d = fetch_count_q;
    mismatch_d    = mismatch_q;
    case (state_q)
      S_IDLE: begin
        if (pr_request_pending) begin
          araddr_d  = FIRST_R_ADDR;
          arvalid_d = 1'b1;
        end
      end
      S_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          rready_d    = 1'b0;
          req_valid_d = 1'b1;
          grid_slot_d = m_axi_rdata[GRID_SLOT_W-1:0];
          ou_id_d     = m_axi_rdata[FIELD_W-1:GRID_SLOT_W];
        end
      end
      S_OUT: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
`ifdef PR_FETCH_PEEK_BEFORE_POP_EN
          araddr_d  = POP_R_ADDR;
          arvalid_d = 1'b1;
`else
          fetch_count_d = fetch_count_q + CNT_W'(1);
`endif
        end
      end
`ifdef PR_FETCH_PEEK_BEFORE_POP_EN
      S_POP_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_POP_R: begin
        if (m_axi_rvalid) begin
          rready_d      = 1'b0;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          if (m_axi_rdata[FIELD_W-1:0] != {ou_id_q, grid_slot_q}) mismatch_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr_q      <= 2'b00;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      req_valid_q   <= 1'b0;
      ou_id_q       <= '0;
      grid_slot_q   <= '0;
      fetch_count_q <= '0;
      busy_q        <= 1'b0;
      mismatch_q    <= 1'b0;
    end else begin
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      req_valid_q   <= req_valid_d;
      ou_id_q       <= ou_id_d;
      grid_slot_q   <= grid_slot_d;
      fetch_count_q <= fetch_count_d;
      busy_q        <= busy_d;
      mismatch_q    <= mismatch_d;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign req_valid     = req_valid_q;
  assign req_ou_id     = ou_id_q;
  assign req_grid_slot = grid_slot_q;
  assign fetch_count   = fetch_count_q;
  assign busy          = busy_q;
`ifdef PR_FETCH_PEEK_BEFORE_POP_EN
  assign mismatch      = mismatch_q;
`else
  assign mismatch      = 1'b0;
`endif

endmodule

// File: doc/axi_pr_request_fetcher.md
Name: axi_pr_request_fetcher

Overview:
- AXI4-Lite read-only initiator for the partial-reconfiguration (PR) request queue.
- Waits for `pr_request_pending` from the queue, reads the oldest request over AXI, and presents it as `{ou_id, grid_slot}` to the downstream PR controller on a valid/ready stream.
- Sits on the management side, between the RCA PR request queue slave and the reconfiguration controller.
- Counts completed fetches for status readback.

Parameters:
- OU_ID_W, 4, width of the ou_id field (upper bits of rdata).
- GRID_SLOT_W, 3, width of the grid_slot field (lower bits of rdata).
- PEEK_R_ADDR, 2'b01, queue peek read address.
- POP_R_ADDR, 2'b10, queue pop read address.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pr_request_pending  in  1  queue non-empty, level.
- m_axi_araddr  out  2  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- req_valid  out  1  request available downstream.
- req_ready  in  1  downstream accepts request.
- req_ou_id  out  OU_ID_W  ou_id of presented request.
- req_grid_slot  out  GRID_SLOT_W  grid_slot of presented request.
- busy  out  1  FSM not in IDLE.
- fetch_count  out  CNT_W  requests delivered downstream.
- mismatch  out  1  sticky peek/pop data mismatch (feature only; 0 otherwise).

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0.
  - araddr=0, arvalid=0, rready=0, req_valid=0, req fields=0, fetch_count=0, mismatch=0.
  - An in-flight AXI transaction is abandoned; the slave is resynchronised by the system reset.
- Outputs are registered; rdata is captured into registers.
- Field extraction from captured rdata:
  - grid_slot = rdata[GRID_SLOT_W-1:0].
  - ou_id = rdata[GRID_SLOT_W+OU_ID_W-1:GRID_SLOT_W].
  - Upper bits are ignored.
- FSM (default build):
  - IDLE: if pr_request_pending=1 -> AR. Set araddr=POP_R_ADDR and arvalid=1 on the transition clock edge.
  - AR: hold arvalid and araddr stable until arready=1. arvalid is never withdrawn early. On the arready cycle, arvalid<=0, rready<=1 -> R.
  - R: rready=1. When rvalid=1, capture fields, rready<=0, req_valid<=1 -> OUT. rvalid arriving any number of cycles later is tolerated.
  - OUT: hold req_valid and fields stable until req_ready=1. On the handshake, req_valid<=0, fetch_count+=1 -> IDLE.
- pending deasserting while in AR: arvalid still held; the transaction completes when the slave accepts.
- Minimum latency: pending rising to req_valid is 3 clk when the slave gives arready and rvalid combinationally. With the queue slave (arready 1 cycle late, rvalid 2 cycles after arready) it is about 5 clk.
- Back-to-back: no new AR issues while in OUT. One request is outstanding at a time.
- A req_ready=1 arriving before req_valid=1 has no effect.
- fetch_count wraps from 2^CNT_W-1 to 0 without a flag.
- busy = (state != IDLE).

Optional Feature:
- Macro: PR_FETCH_PEEK_BEFORE_POP_EN.
- With the macro defined:
  - The first read uses araddr=PEEK_R_ADDR. Its data is presented downstream, but the queue entry is not removed.
  - After the req handshake, the FSM goes to POP_AR/POP_R and issues a POP_R_ADDR read.
  - The pop data is compared with the captured peek data (the GRID_SLOT_W+OU_ID_W field bits). If they differ, mismatch<=1 (sticky until reset).
  - fetch_count increments on pop completion, not on req handshake. The FSM then returns to IDLE.
  - Net effect: an entry leaves the queue only after downstream acceptance.
- Without the macro: single POP read as above; mismatch tied 0; no POP_AR/POP_R states.

Test Plan:
1. Reset mid-AR: assert rst while arvalid=1 -> next cycle arvalid=0, busy=0, fetch_count=0, req_valid=0.
2. Single fetch: pending=1, slave arready after 1 cycle, rdata=32'h0000_002D (ou_id=5, grid_slot=5), req_ready=1 -> araddr=2'b10, req_ou_id=5, req_grid_slot=5, fetch_count=1.
3. Downstream stall: req_ready=0 for 10 cycles after req_valid -> req_valid and fields stable, no further arvalid even with pending=1. Release -> fetch_count increments once.
4. Slave stall: arready=0 for 7 cycles -> arvalid=1 and araddr constant throughout. rvalid delayed 4 cycles -> rready stays 1, capture on rvalid only.
5. Three queued requests {ou=1,gs=2},{ou=3,gs=7},{ou=15,gs=0}, pending held, req_ready=1 -> delivered in order, fetch_count=3. Upper rdata bits 0xFFFFFF80 ignored.
6. Feature on: peek returns 32'h1A, pop returns 32'h1B -> req fields from peek (ou=3, gs=2), then pop read issued after handshake, mismatch=1, fetch_count=1. Equal data -> mismatch stays 0.
